// File: rtl/alu_frame_sequencer.sv
// Collects operand1/operand2/opcode frames, runs one ALU cycle, hands the result to the transmitter.
// Optional WAIT_TX watchdog: define SEQ_TIMEOUT_EN (limit set by TX_TIMEOUT).
module alu_frame_sequencer #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int TX_TIMEOUT = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA+1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_DATA-1:0] o_op_a,
  output logic [NB_DATA-1:0] o_op_b,
  output logic [NB_OP-1:0]   o_op_code,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_operand1_ready,
  output logic               o_operand2_ready,
  output logic               o_opcode_ready,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_error
);

  typedef enum logic [1:0] {IDLE, EXEC, SEND, WAIT_TX} state_t;

  typedef struct packed {
    logic [1:0]         tag;
    logic [NB_DATA-1:0] payload;
  } frame_t;

  state_t state, state_nxt;
  frame_t rx_frm;
  logic   cap_a, cap_b, cap_op, bad_tag, clr_flags, tmo_hit, tmo_fire;

  assign rx_frm = i_rx_data;
  assign o_busy = (state != IDLE);

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)               tmo_cnt <= '0;
    else if (state != WAIT_TX)  tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign tmo_hit = (state == WAIT_TX) && (tmo_cnt == CNT_W'(TX_TIMEOUT - 1));
`else
  // always false; the watchdog is absent and WAIT_TX only exits on i_tx_done
  assign tmo_hit = (TX_TIMEOUT < 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    cap_op    = 1'b0;
    bad_tag   = 1'b0;
    clr_flags = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: if (i_rx_done) begin
        case (rx_frm.tag)
          2'b00:   cap_a   = 1'b1;
          2'b01:   cap_b   = 1'b1;
          2'b10:   cap_op  = 1'b1;
          default: bad_tag = 1'b1;
        endcase
        // launch on the same edge that sets the last missing flag
        if (!bad_tag && (cap_a | o_operand1_ready) && (cap_b | o_operand2_ready) &&
            (cap_op | o_opcode_ready))
          state_nxt = EXEC;
      end
      EXEC:    state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (i_tx_done) begin
        state_nxt = IDLE;
        clr_flags = 1'b1;
      end else if (tmo_hit) begin
        state_nxt = IDLE;
        clr_flags = 1'b1;
        tmo_fire  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_op_a           <= '0;
      o_op_b           <= '0;
      o_op_code        <= '0;
      o_tx_data        <= '0;
      o_tx_start       <= 1'b0;
      o_operand1_ready <= 1'b0;
      o_operand2_ready <= 1'b0;
      o_opcode_ready   <= 1'b0;
      o_overrun        <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      if (cap_a)  o_op_a    <= rx_frm.payload;
      if (cap_b)  o_op_b    <= rx_frm.payload;
      if (cap_op) o_op_code <= rx_frm.payload[NB_OP-1:0];
      if (clr_flags) begin
        o_operand1_ready <= 1'b0;
        o_operand2_ready <= 1'b0;
        o_opcode_ready   <= 1'b0;
      end else begin
        if (cap_a)  o_operand1_ready <= 1'b1;
        if (cap_b)  o_operand2_ready <= 1'b1;
        if (cap_op) o_opcode_ready   <= 1'b1;
      end
      if (state == EXEC) o_tx_data <= i_alu_result;
      // registered off EXEC so the pulse coincides with the single SEND cycle
      o_tx_start <= (state == EXEC);
      o_overrun  <= i_rx_done && (state != IDLE);
      o_error    <= bad_tag | tmo_fire;
    end
  end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed bench for alu_frame_sequencer with a small add/sub ALU model.
module tb_alu_frame_sequencer;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               tb_clk = 1'b0;
  logic               rst_n;
  logic [NB_DATA+1:0] rx_data;
  logic               rx_done, tx_done;
  logic [NB_DATA-1:0] op_a, op_b, tx_data, alu_result;
  logic [NB_OP-1:0]   op_code;
  logic               tx_start, rdy1, rdy2, rdy_op, busy, overrun, error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tb_clk = ~tb_clk;

  // opcode 0x20 add, 0x22 sub, anything else 0
  always_comb begin
    alu_result = '0;
    if (op_code == 6'h20)      alu_result = op_a + op_b;
    else if (op_code == 6'h22) alu_result = op_a - op_b;
  end

  alu_frame_sequencer #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TX_TIMEOUT(16)) dut (
    .i_clk(tb_clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_op_a(op_a), .o_op_b(op_b), .o_op_code(op_code), .i_alu_result(alu_result),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_operand1_ready(rdy1), .o_operand2_ready(rdy2), .o_opcode_ready(rdy_op),
    .o_busy(busy), .o_overrun(overrun), .o_error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send(input logic [9:0] f);
    rx_data = f;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // entered right after the edge that captured the third field
  task automatic tail(input string t, input logic [7:0] exp);
    chk({t, "_busy_exec"}, busy, 1);
    chk({t, "_start_exec"}, tx_start, 0);
    tick();
    chk({t, "_start"}, tx_start, 1);
    chk({t, "_data"}, tx_data, exp);
    tick();
    chk({t, "_start_drop"}, tx_start, 0);
    chk({t, "_busy_wait"}, busy, 1);
    pulse_tx_done();
    chk({t, "_flags_clr"}, {rdy1, rdy2, rdy_op}, 3'b000);
    chk({t, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0;
    #22;
    chk("rst_outs", {op_a, op_b, 2'b0, op_code, tx_data}, 32'h0);
    chk("rst_flags", {tx_start, rdy1, rdy2, rdy_op, busy, overrun, error}, 7'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic triple, add
    send(10'h055);
    chk("t1_op_a", op_a, 8'h55);
    chk("t1_flags1", {rdy1, rdy2, rdy_op}, 3'b100);
    chk("t1_busy1", busy, 0);
    send(10'h1F5);
    send(10'h220);
    chk("t1_op_b", op_b, 8'hF5);
    chk("t1_op_code", op_code, 6'h20);
    chk("t1_flags3", {rdy1, rdy2, rdy_op}, 3'b111);
    tail("t1", 8'h4A);
    chk("t1_keep_a", op_a, 8'h55);

    // subtract, different values so later results are distinguishable
    send(10'h009); send(10'h103); send(10'h222);
    tail("t2", 8'h06);

    // reversed field order
    send(10'h220); send(10'h1F5); send(10'h055);
    tail("t3", 8'h4A);

    // overwrite op1, with a stray tx_done in IDLE
    send(10'h011);
    chk("t4_a1", op_a, 8'h11);
    pulse_tx_done();
    chk("t4_txd_ign", {rdy1, busy}, 2'b10);
    send(10'h055);
    chk("t4_a2", op_a, 8'h55);
    chk("t4_flag", {rdy1, rdy2, rdy_op}, 3'b100);
    send(10'h1F5);
    // invalid tag mid-collection
    send(10'h3AA);
    chk("t5_err", error, 1);
    chk("t5_flags", {rdy1, rdy2, rdy_op}, 3'b110);
    chk("t5_regs", {op_a, op_b}, 16'h55F5);
    tick();
    chk("t5_err_drop", error, 0);
    send(10'h222);
    send(10'h020); send(10'h220);
    // above: op-code 0x22 completed, then 0x020 / 0x220 fall in EXEC/SEND -> dropped
    chk("t5_ovr_send", overrun, 1);
    chk("t5_op_code", op_code, 6'h22);
    chk("t5_a_keep", op_a, 8'h55);
    // now in WAIT_TX
    send(10'h001);
    chk("t6_ovr", overrun, 1);
    chk("t6_a_keep", op_a, 8'h55);
    tick();
    chk("t6_ovr_drop", overrun, 0);
    chk("t6_busy", busy, 1);
    chk("t6_data", tx_data, 8'h60);
    // rx_done coincident with tx_done: frame dropped, transaction closes
    rx_data = 10'h0AA; rx_done = 1'b1; tx_done = 1'b1;
    tick();
    rx_done = 1'b0; tx_done = 1'b0;
    chk("t7_ovr", overrun, 1);
    chk("t7_idle", {busy, rdy1, rdy2, rdy_op}, 4'b0000);
    chk("t7_a_keep", op_a, 8'h55);

    // async reset in WAIT_TX
    send(10'h033); send(10'h111); send(10'h220);
    tick(); tick();
    chk("t8_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_state", busy, 0);
    chk("t8_rst_data", {op_a, op_b, 2'b0, op_code, tx_data}, 32'h0);
    chk("t8_rst_flags", {rdy1, rdy2, rdy_op, tx_start}, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send(10'h055);
    chk("t8_new_txn", {rdy1, rdy2, rdy_op}, 3'b100);
    send(10'h1F5); send(10'h220);
    tail("t8", 8'h4A);

    // WAIT_TX with no tx_done
    send(10'h055); send(10'h1F5); send(10'h220);
    tick(); tick();
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("t9_busy15", {busy, error}, 2'b10);
    tick();
    chk("t9_tmo_err", error, 1);
    chk("t9_tmo_idle", {busy, rdy1, rdy2, rdy_op}, 4'b0000);
    tick();
    chk("t9_err_drop", error, 0);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("t9_still_wait", {busy, error}, 2'b10);
    pulse_tx_done();
    chk("t9_idle", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_frame_sequencer.md
ALU_FRAME_SEQUENCER -- requirements
Module: alu_frame_sequencer

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, operand and result width in bits.
REQ-002 The block SHALL have parameter NB_OP, default 6, ALU opcode width in bits.
REQ-003 The block SHALL have parameter TX_TIMEOUT, default 1000000, clock cycles allowed in WAIT_TX (used only with SEQ_TIMEOUT_EN).
REQ-004 The ports SHALL be, in order: i_clk input 1 system clock, rising edge; i_reset input 1 asynchronous active-low reset.
REQ-005 i_rx_data input NB_DATA+2 received frame: [NB_DATA-1:0] payload, [NB_DATA+1:NB_DATA] tag (00 operand1, 01 operand2, 10 opcode, 11 invalid).
REQ-006 i_rx_done input 1 one-cycle pulse, i_rx_data valid in that cycle.
REQ-007 o_op_a output NB_DATA, o_op_b output NB_DATA, o_op_code output NB_OP: registered ALU operands and opcode.
REQ-008 i_alu_result input NB_DATA combinational ALU result.
REQ-009 o_tx_data output NB_DATA byte to transmitter; o_tx_start output 1 one-cycle start pulse; i_tx_done input 1 one-cycle transmitter completion pulse.
REQ-010 o_operand1_ready, o_operand2_ready, o_opcode_ready outputs 1 each: field captured in current transaction.
REQ-011 o_busy output 1 high when state is not IDLE; o_overrun output 1 one-cycle pulse, frame dropped; o_error output 1 one-cycle pulse, invalid tag or timeout.

Function
REQ-012 States SHALL be IDLE, EXEC, SEND, WAIT_TX, encoded in a registered state variable.
REQ-013 In IDLE, on i_rx_done with tag 00/01/10, the block SHALL load o_op_a / o_op_b / o_op_code (payload[NB_OP-1:0]) and set the matching ready flag at the next edge.
REQ-014 A repeated tag in IDLE SHALL overwrite the register; the flag stays set.
REQ-015 Tag 11 in IDLE SHALL leave all registers and flags unchanged and pulse o_error next cycle.
REQ-016 When the captured frame completes all three flags, the state SHALL become EXEC at the same edge the last flag sets.
REQ-017 EXEC SHALL last one cycle and register i_alu_result into o_tx_data, then move to SEND.
REQ-018 SEND SHALL assert o_tx_start for exactly one cycle, then move to WAIT_TX.
REQ-019 In WAIT_TX, i_tx_done SHALL return the state to IDLE and clear all three ready flags; o_op_a, o_op_b, o_op_code keep their values.
REQ-020 Latency: last field's i_rx_done at cycle N yields o_tx_start high in cycle N+2.
REQ-021 Any i_rx_done while not in IDLE SHALL be dropped and pulse o_overrun next cycle, including when coincident with i_tx_done.
REQ-022 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-023 o_busy SHALL be combinational from the state register.

Reset
REQ-024 Asserting i_reset low SHALL immediately force state IDLE, all data outputs to 0, all flags and pulses to 0, regardless of state.
REQ-025 Reset mid-transaction SHALL discard partial fields; the first post-reset frame starts a new transaction.

Configuration
REQ-026 Macro SEQ_TIMEOUT_EN defined: a counter SHALL run in WAIT_TX; reaching TX_TIMEOUT cycles without i_tx_done returns to IDLE, clears flags, pulses o_error.
REQ-027 Macro SEQ_TIMEOUT_EN undefined: no counter is synthesized and WAIT_TX waits indefinitely for i_tx_done.

Verification
REQ-028 Frames 0x055 (op1=0x55), 0x1F5 (op2=0xF5), 0x220 (opcode 0x20), ALU model add -> o_tx_data=0x4A, o_tx_start 2 cycles after third i_rx_done, flags clear after i_tx_done.
REQ-029 Opcode first, then op2, then op1 (same values) -> identical 0x4A result; order independence.
REQ-030 Op1 0x11 then op1 0x55, op2 0xF5, opcode 0x20 -> o_op_a=0x55, result 0x4A.
REQ-031 Frame 0x3AA in IDLE -> o_error one cycle, no flag change; frame 0x001 during WAIT_TX -> o_overrun one cycle, o_op_a unchanged.
REQ-032 i_reset low during WAIT_TX -> state IDLE, all outputs 0 asynchronously; next full triple completes normally.
REQ-033 With SEQ_TIMEOUT_EN, TX_TIMEOUT=16, no i_tx_done -> o_error pulse after 16 WAIT_TX cycles, o_busy low.
